// File: rtl/dmem.sv
// Data memory: 2^r words of n bits, combinational read, clocked write, async clear on rst.
// Optional macro DMEM_BYTE_ADDR_EN selects byte addressing (index = addr[r+1:2]); default is word addressing.
module dmem #(
  parameter int n = 32,
  parameter int r = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         writeEnable,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writeData,
  output logic [n-1:0] readData
);

  localparam int depth = 1 << r;

  logic [n-1:0] mem [depth];
  logic [r-1:0] index;
  logic         unused_addr;

`ifdef DMEM_BYTE_ADDR_EN
  assign index = addr[r+1:2];
`else
  assign index = addr[r-1:0];
`endif

  // Bits outside the index are deliberately ignored so that aliased addresses hit the same word.
  assign unused_addr = ^addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (writeEnable) begin
      mem[index] <= writeData;
    end
  end

  // Gate the read path so readData is zero for the whole time rst is high, not just after the clear.
  assign readData = rst ? '0 : mem[index];

endmodule

// File: tb/tb_dmem.sv
// tb/tb_dmem.sv - randomized self-checking bench for dmem against an array reference model.
module tb_dmem;
  localparam int N = 32;
  localparam int R = 7;
  localparam int DEPTH = 1 << R;

  logic         clk = 1'b0;
  logic         rst;
  logic         writeEnable;
  logic [N-1:0] addr;
  logic [N-1:0] writeData;
  logic [N-1:0] readData;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] model [DEPTH];

  always #5 clk = ~clk;

  dmem #(.n(N), .r(R)) dut (
    .clk(clk),
    .rst(rst),
    .writeEnable(writeEnable),
    .addr(addr),
    .writeData(writeData),
    .readData(readData)
  );

  function automatic int word_of(input logic [N-1:0] a);
`ifdef DMEM_BYTE_ADDR_EN
    return int'((a / 4) % DEPTH);
`else
    return int'(a % DEPTH);
`endif
  endfunction

  function automatic logic [N-1:0] alias_of(input logic [N-1:0] a);
    logic [N-1:0] hi;
    hi = $urandom;
    return a | (hi << (R + 2));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [N-1:0] a, input logic [N-1:0] d);
    @(negedge clk);
    addr = a; writeData = d; writeEnable = 1'b1;
    @(posedge clk);
    model[word_of(a)] = d;
    #1 writeEnable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; writeEnable = 1'b0; addr = '0; writeData = '0;
    clear_model();
    for (int i = 0; i < 6; i++) begin
      #3 addr = $urandom;
      #1;
      checks++;
      if (readData !== '0) begin
        errors++;
        $display("FAIL reset_hold addr=%h got=%h exp=0", addr, readData);
      end
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = $urandom;
      #1;
      checks++;
      if (readData !== '0) begin
        errors++;
        $display("FAIL reset_release addr=%h got=%h exp=0", addr, readData);
      end
    end
  endtask

  task automatic test_alias_write();
    logic [N-1:0] a;
    @(negedge clk);
    addr = 32'h15; writeData = 32'hDEADBEEF; writeEnable = 1'b1;
    #1;
    checks++;
    if (readData !== model[word_of(32'h15)]) begin
      errors++;
      $display("FAIL pre_edge_old addr=15 got=%h exp=%h", readData, model[word_of(32'h15)]);
    end
    @(posedge clk);
    model[word_of(32'h15)] = 32'hDEADBEEF;
    #1 writeEnable = 1'b0;
    #1;
    checks++;
    if (readData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL post_edge_new addr=15 got=%h exp=deadbeef", readData);
    end
    addr = 32'h14;
    #1;
    checks++;
    if (readData !== model[word_of(32'h14)]) begin
      errors++;
      $display("FAIL alias_14 got=%h exp=%h", readData, model[word_of(32'h14)]);
    end
    a = alias_of(32'h15);
    addr = a;
    #1;
    checks++;
    if (readData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alias_high addr=%h got=%h exp=deadbeef", a, readData);
    end
  endtask

  task automatic test_multi_write();
    logic [N-1:0] addrs [3];
    addrs[0] = 32'h2A; addrs[1] = 32'h3F; addrs[2] = 32'h15;
    do_write(32'h2A, 32'hACACACAC);
    do_write(32'h3F, 32'hBCBCBCBC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) addr = addrs[i];
      #1;
      checks++;
      if (readData !== model[word_of(addrs[i])]) begin
        errors++;
        $display("FAIL multi_read addr=%h got=%h exp=%h", addrs[i], readData, model[word_of(addrs[i])]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    addr = 32'h2A; writeEnable = 1'b0; writeData = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (readData !== model[word_of(32'h2A)]) begin
      errors++;
      $display("FAIL hold_no_we got=%h exp=%h", readData, model[word_of(32'h2A)]);
    end
  endtask

  task automatic test_between_edges();
    logic [N-1:0] a1, a2, a3, d1, d2, d3;
    a1 = $urandom; a2 = $urandom; a3 = $urandom;
    d1 = $urandom; d2 = $urandom; d3 = $urandom;
    @(negedge clk);
    addr = a1; writeData = d1; writeEnable = 1'b1;
    #1 addr = a2; writeData = d2;
    #1;
    checks++;
    if (readData !== model[word_of(a2)]) begin
      errors++;
      $display("FAIL mid_cycle_a2 got=%h exp=%h", readData, model[word_of(a2)]);
    end
    addr = a1;
    #1;
    checks++;
    if (readData !== model[word_of(a1)]) begin
      errors++;
      $display("FAIL mid_cycle_a1 got=%h exp=%h", readData, model[word_of(a1)]);
    end
    addr = a3; writeData = d3;
    @(posedge clk);
    model[word_of(a3)] = d3;
    #1 writeEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = (i == 0) ? a1 : (i == 1) ? a2 : a3;
      #1;
      checks++;
      if (readData !== model[word_of(addr)]) begin
        errors++;
        $display("FAIL edge_sampled addr=%h got=%h exp=%h", addr, readData, model[word_of(addr)]);
      end
    end
  endtask

  task automatic test_x_enable();
    @(negedge clk);
    addr = 32'h3F; writeData = 32'h0BADF00D; writeEnable = 1'bx;
    @(posedge clk);
    #1 writeEnable = 1'b0;
    #1;
    checks++;
    if (readData !== model[word_of(32'h3F)]) begin
      errors++;
      $display("FAIL x_enable got=%h exp=%h", readData, model[word_of(32'h3F)]);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, d;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if (i < 150) a = a % 64;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_write(a, d);
      end else begin
        @(negedge clk) addr = a;
        #1;
        checks++;
        if (readData !== model[word_of(a)]) begin
          errors++;
          $display("FAIL random_read addr=%h got=%h exp=%h", a, readData, model[word_of(a)]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    addr = 32'h2A; writeData = 32'h55AA55AA; writeEnable = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (readData !== '0) begin
      errors++;
      $display("FAIL rst_immediate got=%h exp=0", readData);
    end
    @(posedge clk);
    #1;
    checks++;
    if (readData !== '0) begin
      errors++;
      $display("FAIL rst_through_edge got=%h exp=0", readData);
    end
    @(negedge clk);
    writeEnable = 1'b0;
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < DEPTH; i++) begin
`ifdef DMEM_BYTE_ADDR_EN
      addr = i * 4;
`else
      addr = i;
`endif
      #1;
      checks++;
      if (readData !== model[i]) begin
        errors++;
        $display("FAIL post_rst_clear word=%0d got=%h exp=%h", i, readData, model[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alias_write();
    test_multi_write();
    test_hold();
    test_between_edges();
    test_x_enable();
    test_random();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
